// File: rtl/wb_load_stage_if.sv
// Memory-stage retire bus, data-bus read response and register-file write port of the writeback stage.
interface wb_load_stage_if;
  logic        in_valid;
  logic        except;
  logic [2:0]  in_kind;
  logic [1:0]  in_addr_lo;
  logic        in_wen;
  logic [4:0]  in_waddr;
  logic [31:0] in_result;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        stall;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        bus_timeout;

  modport master (
    output in_valid, except, in_kind, in_addr_lo, in_wen, in_waddr, in_result,
    output dbus_rvalid, dbus_rdata,
    input  stall, reg_we, reg_waddr, reg_wdata, bus_timeout
  );

  modport slave (
    input  in_valid, except, in_kind, in_addr_lo, in_wen, in_waddr, in_result,
    input  dbus_rvalid, dbus_rdata,
    output stall, reg_we, reg_waddr, reg_wdata, bus_timeout
  );
endinterface

// File: rtl/wb_load_stage.sv
// Writeback stage: registers retiring results (1-cycle latency), waits for load data with stall held
// while a load is outstanding, aligns/extends/merges it, and abandons loads after TIMEOUT wait cycles.
module wb_load_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  wb_load_stage_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [2:0] K_LW  = 3'd0;
  localparam logic [2:0] K_LH  = 3'd1;
  localparam logic [2:0] K_LHU = 3'd2;
  localparam logic [2:0] K_LB  = 3'd3;
  localparam logic [2:0] K_LBU = 3'd4;
  localparam logic [2:0] K_LWL = 3'd5;
  localparam logic [2:0] K_LWR = 3'd6;
  localparam logic [2:0] K_NONE = 3'd7;

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    kind_q, kind_d;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic          wen_q, wen_d;
  logic [4:0]    waddr_q, waddr_d;
  logic [31:0]   rt_old_q, rt_old_d;
  logic          reg_we_q, reg_we_d;
  logic [4:0]    reg_waddr_q, reg_waddr_d;
  logic [31:0]   reg_wdata_q, reg_wdata_d;
  logic          bus_timeout_q, bus_timeout_d;

  logic          accept;
  logic [31:0]   ld_data;
  logic [15:0]   half;
  logic [7:0]    byte_sel;

  assign accept = bus.in_valid && !bus.except && (state_q == ST_IDLE);

  // Alignment uses the latched offset and the old rt value captured at accept.
  always_comb begin
    half     = addr_lo_q[1] ? bus.dbus_rdata[31:16] : bus.dbus_rdata[15:0];
    byte_sel = bus.dbus_rdata[8*addr_lo_q +: 8];
    ld_data  = bus.dbus_rdata;
    case (kind_q)
      K_LW:  ld_data = bus.dbus_rdata;
      K_LH:  ld_data = {{16{half[15]}}, half};
      K_LHU: ld_data = {16'h0000, half};
      K_LB:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      K_LBU: ld_data = {24'h000000, byte_sel};
      K_LWL: begin
        case (addr_lo_q)
          2'd0:    ld_data = {bus.dbus_rdata[7:0],  rt_old_q[23:0]};
          2'd1:    ld_data = {bus.dbus_rdata[15:0], rt_old_q[15:0]};
          2'd2:    ld_data = {bus.dbus_rdata[23:0], rt_old_q[7:0]};
          default: ld_data = bus.dbus_rdata;
        endcase
      end
      K_LWR: begin
        case (addr_lo_q)
          2'd0:    ld_data = bus.dbus_rdata;
          2'd1:    ld_data = {rt_old_q[31:24], bus.dbus_rdata[31:8]};
          2'd2:    ld_data = {rt_old_q[31:16], bus.dbus_rdata[31:16]};
          default: ld_data = {rt_old_q[31:8],  bus.dbus_rdata[31:24]};
        endcase
      end
      default: ld_data = bus.dbus_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    kind_d        = kind_q;
    addr_lo_d     = addr_lo_q;
    wen_d         = wen_q;
    waddr_d       = waddr_q;
    rt_old_d      = rt_old_q;
    reg_we_d      = 1'b0;
    reg_waddr_d   = reg_waddr_q;
    reg_wdata_d   = reg_wdata_q;
    bus_timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.in_kind == K_NONE) begin
            reg_we_d = bus.in_wen;
            if (bus.in_wen) begin
              reg_waddr_d = bus.in_waddr;
              reg_wdata_d = bus.in_result;
            end
          end else begin
            kind_d    = bus.in_kind;
            addr_lo_d = bus.in_addr_lo;
            wen_d     = bus.in_wen;
            waddr_d   = bus.in_waddr;
            rt_old_d  = bus.in_result;
            cnt_d     = '0;
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // except and in_valid are deliberately ignored: the waiting load is older and committed.
        if (bus.dbus_rvalid) begin
          reg_we_d = wen_q;
          if (wen_q) begin
            reg_waddr_d = waddr_q;
            reg_wdata_d = ld_data;
          end
          state_d = ST_IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          bus_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      kind_q        <= K_NONE;
      addr_lo_q     <= 2'd0;
      wen_q         <= 1'b0;
      waddr_q       <= 5'd0;
      rt_old_q      <= 32'h0;
      reg_we_q      <= 1'b0;
      reg_waddr_q   <= 5'd0;
      reg_wdata_q   <= 32'h0;
      bus_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      kind_q        <= kind_d;
      addr_lo_q     <= addr_lo_d;
      wen_q         <= wen_d;
      waddr_q       <= waddr_d;
      rt_old_q      <= rt_old_d;
      reg_we_q      <= reg_we_d;
      reg_waddr_q   <= reg_waddr_d;
      reg_wdata_q   <= reg_wdata_d;
      bus_timeout_q <= bus_timeout_d;
    end
  end

  assign bus.stall       = (state_q == ST_WAIT) && !bus.dbus_rvalid;
  assign bus.reg_we      = reg_we_q;
  assign bus.reg_waddr   = reg_waddr_q;
  assign bus.reg_wdata   = reg_wdata_q;
  assign bus.bus_timeout = bus_timeout_q;

endmodule

// File: tb/tb_wb_load_stage.sv
// Directed bench for wb_load_stage: ALU writes, load alignment, exceptions, timeout and reset abort.
module tb_wb_load_stage;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_load_stage_if bus ();

  wb_load_stage #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.in_valid    = 1'b0;
    bus.except      = 1'b0;
    bus.in_kind     = 3'd7;
    bus.in_addr_lo  = 2'd0;
    bus.in_wen      = 1'b0;
    bus.in_waddr    = 5'd0;
    bus.in_result   = 32'h0;
    bus.dbus_rvalid = 1'b0;
    bus.dbus_rdata  = 32'h0;
  endtask

  task automatic offer(input logic [2:0] kind, input logic [1:0] lo, input logic wen,
                       input logic [4:0] waddr, input logic [31:0] result);
    bus.in_valid   = 1'b1;
    bus.in_kind    = kind;
    bus.in_addr_lo = lo;
    bus.in_wen     = wen;
    bus.in_waddr   = waddr;
    bus.in_result  = result;
  endtask

  // Accept a load, answer it 3 cycles after accept, then check the write (or its absence).
  task automatic do_load(input string tag, input logic [2:0] kind, input logic [1:0] lo,
                         input logic wen, input logic [4:0] waddr, input logic [31:0] rt,
                         input logic [31:0] d, input logic [31:0] exp_wdata);
    tick(); idle_in(); offer(kind, lo, wen, waddr, rt);
    mid();  chk({tag, "_stall_acc"}, 32'(bus.stall), 32'd0);
    tick(); idle_in();
    mid();  chk({tag, "_stall_w1"}, 32'(bus.stall), 32'd1);
    tick();
    mid();  chk({tag, "_stall_w2"}, 32'(bus.stall), 32'd1);
    tick(); bus.dbus_rvalid = 1'b1; bus.dbus_rdata = d;
    mid();  chk({tag, "_stall_rv"}, 32'(bus.stall), 32'd0);
    tick(); idle_in();
    mid();
    chk({tag, "_we"}, 32'(bus.reg_we), 32'(wen));
    chk({tag, "_waddr"}, 32'(bus.reg_waddr), 32'(waddr));
    chk({tag, "_wdata"}, bus.reg_wdata, exp_wdata);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_in();
    rst = 1'b1;
    tick(); tick();
    mid();
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_we", 32'(bus.reg_we), 32'd0);
    chk("rst_waddr", 32'(bus.reg_waddr), 32'd0);
    chk("rst_wdata", bus.reg_wdata, 32'h0);
    chk("rst_tmo", 32'(bus.bus_timeout), 32'd0);
    tick(); rst = 1'b0;

    // ALU result, 1-cycle latency
    tick(); offer(3'd7, 2'd0, 1'b1, 5'd8, 32'h1234_5678);
    mid();  chk("alu_stall", 32'(bus.stall), 32'd0);
    tick(); idle_in();
    mid();
    chk("alu_we", 32'(bus.reg_we), 32'd1);
    chk("alu_waddr", 32'(bus.reg_waddr), 32'd8);
    chk("alu_wdata", bus.reg_wdata, 32'h1234_5678);
    chk("alu_stall2", 32'(bus.stall), 32'd0);
    tick();
    mid();
    chk("alu_we_pulse", 32'(bus.reg_we), 32'd0);
    chk("alu_wdata_hold", bus.reg_wdata, 32'h1234_5678);

    do_load("lb",   3'd3, 2'd2, 1'b1, 5'd9,  32'h0,         32'h0080_0000, 32'hFFFF_FF80);
    do_load("lbu",  3'd4, 2'd2, 1'b1, 5'd10, 32'h0,         32'h0080_0000, 32'h0000_0080);
    do_load("lwl",  3'd5, 2'd1, 1'b1, 5'd11, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344);
    do_load("lwr",  3'd6, 2'd1, 1'b1, 5'd12, 32'h1122_3344, 32'hAABB_CCDD, 32'h11AA_BBCC);
    do_load("lh",   3'd1, 2'd0, 1'b1, 5'd13, 32'h0,         32'h0000_8001, 32'hFFFF_8001);
    do_load("lhu",  3'd2, 2'd2, 1'b1, 5'd14, 32'h0,         32'h8001_1234, 32'h0000_8001);
    do_load("lw",   3'd0, 2'd0, 1'b1, 5'd15, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("lwl3", 3'd5, 2'd3, 1'b1, 5'd16, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD);
    // no-write load: handshake runs, no write, waddr/wdata keep the previous write
    do_load("lw_nowen", 3'd0, 2'd0, 1'b0, 5'd16, 32'h0, 32'h5555_AAAA, 32'hAABB_CCDD);

    // LH cancelled by an exception; later rvalid ignored
    tick(); offer(3'd1, 2'd0, 1'b1, 5'd20, 32'h0); bus.except = 1'b1;
    mid();  chk("exc_stall0", 32'(bus.stall), 32'd0);
    tick(); idle_in();
    mid();
    chk("exc_stall1", 32'(bus.stall), 32'd0);
    chk("exc_we1", 32'(bus.reg_we), 32'd0);
    tick(); bus.dbus_rvalid = 1'b1; bus.dbus_rdata = 32'h0000_7777;
    mid();  chk("exc_stall2", 32'(bus.stall), 32'd0);
    tick(); idle_in();
    mid();
    chk("exc_we3", 32'(bus.reg_we), 32'd0);
    chk("exc_wdata_hold", bus.reg_wdata, 32'hAABB_CCDD);

    // timeout: 4 stalled cycles, then pulse in the first IDLE cycle
    tick(); offer(3'd0, 2'd0, 1'b1, 5'd21, 32'h0);
    mid();
    for (int i = 0; i < 4; i++) begin
      tick(); idle_in();
      mid();
      chk($sformatf("tmo_stall%0d", i), 32'(bus.stall), 32'd1);
      chk($sformatf("tmo_pulse_early%0d", i), 32'(bus.bus_timeout), 32'd0);
    end
    tick();
    mid();
    chk("tmo_pulse", 32'(bus.bus_timeout), 32'd1);
    chk("tmo_stall_end", 32'(bus.stall), 32'd0);
    chk("tmo_we", 32'(bus.reg_we), 32'd0);
    tick(); bus.dbus_rvalid = 1'b1; bus.dbus_rdata = 32'h1111_2222;
    mid();
    chk("tmo_pulse_off", 32'(bus.bus_timeout), 32'd0);
    chk("tmo_late_stall", 32'(bus.stall), 32'd0);
    tick(); idle_in();
    mid();
    chk("tmo_late_we", 32'(bus.reg_we), 32'd0);
    chk("tmo_late_wdata", bus.reg_wdata, 32'hAABB_CCDD);

    // reset in the second WAIT cycle aborts the load
    tick(); offer(3'd0, 2'd0, 1'b1, 5'd22, 32'h0);
    mid();
    tick(); idle_in();
    mid();  chk("rstw_stall1", 32'(bus.stall), 32'd1);
    tick(); rst = 1'b1;
    mid();  chk("rstw_stall2", 32'(bus.stall), 32'd1);
    tick(); rst = 1'b0; offer(3'd7, 2'd0, 1'b1, 5'd12, 32'hCAFE_F00D);
    mid();
    chk("rstw_stall", 32'(bus.stall), 32'd0);
    chk("rstw_we", 32'(bus.reg_we), 32'd0);
    chk("rstw_waddr", 32'(bus.reg_waddr), 32'd0);
    chk("rstw_wdata", bus.reg_wdata, 32'h0);
    chk("rstw_tmo", 32'(bus.bus_timeout), 32'd0);
    tick(); idle_in();
    mid();
    chk("post_rst_we", 32'(bus.reg_we), 32'd1);
    chk("post_rst_waddr", 32'(bus.reg_waddr), 32'd12);
    chk("post_rst_wdata", bus.reg_wdata, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_load_stage.md
Name: wb_load_stage

Overview:
- Writeback stage directly downstream of the memory stage.
- Registers each retiring instruction and, for loads, waits for the data-bus read response.
- Aligns, extends or merges the returned word (LB/LBU/LH/LHU/LW/LWL/LWR) and drives the register-file write port.
- Back-pressures the pipeline with `stall` while a load is outstanding, and aborts loads whose response never arrives.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles before abandoning a load; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  memory stage holds a retiring instruction this cycle
- except  input  1  memory-stage exception; cancels the instruction offered this cycle
- in_kind  input  3  load kind: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 LWL, 6 LWR, 7 non-load
- in_addr_lo  input  2  byte offset, dbus_addr[1:0] of the issued access
- in_wen  input  1  instruction writes a GPR
- in_waddr  input  5  destination GPR
- in_result  input  32  ALU/CP0 result (non-load); old rt value (LWL/LWR merge)
- dbus_rvalid  input  1  read data valid, single-cycle pulse
- dbus_rdata  input  32  read data, little-endian word
- stall  output  1  hold the upstream pipeline
- reg_we  output  1  register-file write enable
- reg_waddr  output  5  register-file write address
- reg_wdata  output  32  register-file write data
- bus_timeout  output  1  one-cycle pulse when a load is abandoned

Behaviour:
- Reset: state IDLE; timeout counter 0; all outputs 0 (stall, reg_we, reg_waddr, reg_wdata, bus_timeout).
- accept = in_valid && !except && state==IDLE. With except=1, nothing is latched and nothing is written.
- IDLE, accept, in_kind==7: on the next cycle reg_we=in_wen, reg_waddr=in_waddr, reg_wdata=in_result. Latency is 1; state stays IDLE.
- IDLE, accept, in_kind!=7:
  - Latch kind, addr_lo, wen, waddr and in_result as rt_old.
  - Go to WAIT; counter cleared. reg_we=0 the next cycle.
- WAIT:
  - stall = !dbus_rvalid (combinational). in_valid is ignored; upstream is held by stall.
  - except is ignored: the waiting load is older and already committed.
  - On dbus_rvalid: extract data and present it next cycle with reg_we=latched wen. Go to IDLE; the counter increments only while no rvalid.
  - A response in the same cycle as entering WAIT is impossible: the response arrives at least 1 cycle after the request.
- Timeout (TIMEOUT>0): counter reaches TIMEOUT-1 with no rvalid →
  - bus_timeout=1 for one cycle and reg_we=0.
  - Return to IDLE.
  - A late rvalid arriving in IDLE is ignored.
- stall=0 in IDLE. Every state change is registered.
- reg_we is a single-cycle pulse per instruction. reg_waddr/reg_wdata hold their last values when reg_we=0.
- Extraction (b = addr_lo, d = dbus_rdata):
  - LW: d.
  - LH/LHU: h = b[1] ? d[31:16] : d[15:0]; sign- or zero-extend to 32.
  - LB/LBU: byte d[8b+7:8b]; sign- or zero-extend.
  - LWL: (d << 8*(3-b)) | (rt_old & (32'hFFFFFFFF >> 8*(b+1))); b=3 gives d.
  - LWR: (d >> 8*b) | (rt_old & ~(32'hFFFFFFFF >> 8*b)); b=0 gives d.
  - Misalignment is not checked here; the memory stage raises it as an exception and the load never reaches this block.
- rst in WAIT: immediate return to IDLE next edge; the pending write is discarded and stall=0 after the edge.
- in_wen=0 load (e.g. to $0 decoded as no-write): the WAIT handshake still runs; reg_we stays 0.

Test Plan:
- ALU op in_kind=7, wen=1, waddr=8, result=32'h1234_5678 → next cycle reg_we=1, reg_waddr=8, reg_wdata=32'h1234_5678; stall never asserted.
- LB, addr_lo=2, rvalid 3 cycles after accept with d=32'h0080_0000 →
  - stall=1 for exactly 2 cycles, then 0 in the rvalid cycle.
  - Next cycle reg_wdata=32'hFFFF_FF80.
  - The LBU variant gives 32'h0000_0080.
- LWL addr_lo=1, d=32'hAABB_CCDD, rt_old=32'h1122_3344 → reg_wdata=32'hCCDD_3344; LWR addr_lo=1, same inputs → 32'h11AA_BBCC.
- LH with except=1 on the offer cycle → no state change, stall=0, reg_we=0; an rvalid pulse two cycles later is ignored.
- TIMEOUT=4, LW with no rvalid → stall=1 for 4 cycles; bus_timeout pulse as the state returns to IDLE; no reg_we; an rvalid 2 cycles later has no effect.
- rst asserted in the second WAIT cycle → all outputs 0 after the edge; a following ALU op writes normally with 1-cycle latency.
